// File: rtl/riscv_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_pipeline : 5-stage RV32I OP/OP-IMM core; RISCV_FORWARD_EN = bypass   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module riscv_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o,
  output logic        we_o,
  output logic [3:0]  alu_fn_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o
);
  logic [31:0] reg_file [0:31];
  logic        is_op, is_opi, alt;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_val, rs2_val;

  assign is_op      = (instr_i[6:0] == 7'b0110011);
  assign is_opi     = (instr_i[6:0] == 7'b0010011);
  assign funct3     = instr_i[14:12];
  assign rs1_o      = instr_i[19:15];
  assign rs2_o      = instr_i[24:20];
  assign rd_o       = instr_i[11:7];
  assign imm        = {{20{instr_i[31]}}, instr_i[31:20]};
  assign rs1_used_o = is_op | is_opi;
  assign rs2_used_o = is_op;
  assign we_o       = (is_op | is_opi) && (rd_o != 5'd0);
  // OP-IMM only carries the alternate bit for srai; addi with a negative imm must stay an add
  assign alt        = is_op ? instr_i[30] : (funct3 == 3'b101) && instr_i[30];
  assign alu_fn_o   = {alt, funct3};

  always_comb begin
    rs1_val = reg_file[rs1_o];
    rs2_val = reg_file[rs2_o];
    if (wb_we_i && wb_rd_i == rs1_o) rs1_val = wb_data_i;
    if (wb_we_i && wb_rd_i == rs2_o) rs2_val = wb_data_i;
    if (rs1_o == 5'd0) rs1_val = 32'd0;
    if (rs2_o == 5'd0) rs2_val = 32'd0;
  end

  assign op_a_o = rs1_val;
  assign op_b_o = is_op ? rs2_val : imm;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 32; i++) reg_file[i] <= 32'd0;
    end else if (wb_we_i && wb_rd_i != 5'd0) begin
      reg_file[wb_rd_i] <= wb_data_i;
    end
  end
endmodule

module riscv_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc_q, pc_d, ifid_instr_q;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_rs1_used, dec_rs2_used, dec_we;
  logic [3:0]  dec_fn;
  logic [31:0] dec_a, dec_b;
  logic [31:0] idex_a_q, idex_b_q;
  logic [4:0]  idex_rd_q;
  logic        idex_we_q;
  logic [3:0]  idex_fn_q;
  logic [31:0] exmem_res_q, memwb_res_q;
  logic [4:0]  exmem_rd_q, memwb_rd_q;
  logic        exmem_we_q, memwb_we_q;
  logic        stall;
  logic [31:0] fwd_a, fwd_b, alu_res;

  riscv_decode u_decode (
    .clk(clk), .rst_n(rst_n), .instr_i(ifid_instr_q),
    .wb_we_i(memwb_we_q), .wb_rd_i(memwb_rd_q), .wb_data_i(memwb_res_q),
    .rs1_o(dec_rs1), .rs2_o(dec_rs2), .rd_o(dec_rd),
    .rs1_used_o(dec_rs1_used), .rs2_used_o(dec_rs2_used), .we_o(dec_we),
    .alu_fn_o(dec_fn), .op_a_o(dec_a), .op_b_o(dec_b)
  );

`ifdef RISCV_FORWARD_EN
  logic [4:0] idex_rs1_q, idex_rs2_q;

  // Unused source fields are recorded as x0 so they never match a producer
  always_ff @(posedge clk) begin
    if (rst_n) begin
      idex_rs1_q <= 5'd0;
      idex_rs2_q <= 5'd0;
    end else begin
      idex_rs1_q <= dec_rs1_used ? dec_rs1 : 5'd0;
      idex_rs2_q <= dec_rs2_used ? dec_rs2 : 5'd0;
    end
  end

  always_comb begin
    fwd_a = idex_a_q;
    fwd_b = idex_b_q;
    if (idex_rs1_q != 5'd0 && exmem_we_q && exmem_rd_q == idex_rs1_q) fwd_a = exmem_res_q;
    else if (idex_rs1_q != 5'd0 && memwb_we_q && memwb_rd_q == idex_rs1_q) fwd_a = memwb_res_q;
    if (idex_rs2_q != 5'd0 && exmem_we_q && exmem_rd_q == idex_rs2_q) fwd_b = exmem_res_q;
    else if (idex_rs2_q != 5'd0 && memwb_we_q && memwb_rd_q == idex_rs2_q) fwd_b = memwb_res_q;
  end

  assign stall = 1'b0;
`else
  assign fwd_a = idex_a_q;
  assign fwd_b = idex_b_q;
  assign stall =
    (dec_rs1_used && dec_rs1 != 5'd0 &&
     ((idex_we_q && idex_rd_q == dec_rs1) || (exmem_we_q && exmem_rd_q == dec_rs1))) ||
    (dec_rs2_used && dec_rs2 != 5'd0 &&
     ((idex_we_q && idex_rd_q == dec_rs2) || (exmem_we_q && exmem_rd_q == dec_rs2)));
`endif

  always_comb begin
    alu_res = 32'd0;
    case (idex_fn_q[2:0])
      3'b000:  alu_res = idex_fn_q[3] ? fwd_a - fwd_b : fwd_a + fwd_b;
      3'b001:  alu_res = fwd_a << fwd_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(fwd_a) < $signed(fwd_b)};
      3'b011:  alu_res = {31'd0, fwd_a < fwd_b};
      3'b100:  alu_res = fwd_a ^ fwd_b;
      3'b101:  alu_res = idex_fn_q[3] ? 32'($signed(fwd_a) >>> fwd_b[4:0]) : fwd_a >> fwd_b[4:0];
      3'b110:  alu_res = fwd_a | fwd_b;
      default: alu_res = fwd_a & fwd_b;
    endcase
  end

  assign pc_d = stall ? pc_q : pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q         <= 32'd0;
      ifid_instr_q <= 32'h0000_0013;
      idex_a_q     <= 32'd0;
      idex_b_q     <= 32'd0;
      idex_rd_q    <= 5'd0;
      idex_we_q    <= 1'b0;
      idex_fn_q    <= 4'd0;
      exmem_res_q  <= 32'd0;
      exmem_rd_q   <= 5'd0;
      exmem_we_q   <= 1'b0;
      memwb_res_q  <= 32'd0;
      memwb_rd_q   <= 5'd0;
      memwb_we_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (!stall) ifid_instr_q <= instr_i;
      if (stall) begin
        idex_a_q  <= 32'd0;
        idex_b_q  <= 32'd0;
        idex_rd_q <= 5'd0;
        idex_we_q <= 1'b0;
        idex_fn_q <= 4'd0;
      end else begin
        idex_a_q  <= dec_a;
        idex_b_q  <= dec_b;
        idex_rd_q <= dec_rd;
        idex_we_q <= dec_we;
        idex_fn_q <= dec_fn;
      end
      exmem_res_q <= alu_res;
      exmem_rd_q  <= idex_rd_q;
      exmem_we_q  <= idex_we_q;
      memwb_res_q <= exmem_res_q;
      memwb_rd_q  <= exmem_rd_q;
      memwb_we_q  <= exmem_we_q;
    end
  end

  assign pc_o = pc_q;
endmodule

module riscv_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrF,
  output logic [31:0] pcF
);
  riscv_core core_inst (
    .clk(clk), .rst_n(rst_n), .instr_i(instrF), .pc_o(pcF)
  );
endmodule

`default_nettype wire

// File: tb/tb_riscv_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_pipeline : directed programs with a register-file scoreboard      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_riscv_pipeline;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instrF, pcF;
  logic [31:0] imem [0:255];
  int          n_pass = 0;
  int          n_total = 0;

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  riscv_pipeline dut (.clk(clk), .rst_n(rst_n), .instrF(instrF), .pcF(pcF));

  always #5 clk = ~clk;

  always_comb instrF = (pcF[31:10] == 22'd0) ? imem[pcF[9:2]] : NOP;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic int nonzero_regs();
    int n = 0;
    for (int i = 0; i < 32; i++)
      if (dut.core_inst.u_decode.reg_file[i] !== 32'd0) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = NOP;
  endtask

  task automatic push(input string tag, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, dut.core_inst.u_decode.reg_file[e.idx], e.val);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_addsub();
    clear_prog();
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
    imem[1] = enc_i(12'd7, 5'd0, 3'b000, 5'd2);
    imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    imem[3] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
  endtask

  task automatic push_addsub(input string pfx);
    push({pfx, "_x1"}, 1, 32'd5);
    push({pfx, "_x2"}, 2, 32'd7);
    push({pfx, "_x3"}, 3, 32'd12);
    push({pfx, "_x4"}, 4, 32'hFFFF_FFFE);
  endtask

  initial begin
    rst_n = 1'b1;
    clear_prog();

    // add/sub program, reset state first
    load_addsub();
    run(2);
    reset_pulse();
    check("reset_pc", pcF, 32'd0);
    check("reset_regs_nonzero", 32'(nonzero_regs()), 32'd0);
    push_addsub("addsub");
    run(300);
    drain();

    // shifts and compares
    clear_prog();
    imem[0] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd5);
    imem[1] = enc_i(12'd31, 5'd5, 3'b001, 5'd6);
    imem[2] = enc_i({7'h20, 5'd4}, 5'd6, 3'b101, 5'd7);
    imem[3] = enc_i(12'd4, 5'd6, 3'b101, 5'd8);
    imem[4] = enc_r(7'h00, 5'd0, 5'd6, 3'b010, 5'd9);
    imem[5] = enc_r(7'h00, 5'd0, 5'd6, 3'b011, 5'd10);
    reset_pulse();
    push("shift_x5", 5, 32'hFFFF_FFFF);
    push("shift_x6", 6, 32'h8000_0000);
    push("shift_x7", 7, 32'hF800_0000);
    push("shift_x8", 8, 32'h0800_0000);
    push("shift_x9", 9, 32'd1);
    push("shift_x10", 10, 32'd0);
    run(60);
    drain();

    // logic ops
    clear_prog();
    imem[0] = enc_i(12'h0F0, 5'd0, 3'b000, 5'd1);
    imem[1] = enc_i(12'h0FF, 5'd0, 3'b000, 5'd2);
    imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd11);
    imem[3] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd12);
    imem[4] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd13);
    reset_pulse();
    push("logic_x11", 11, 32'h0000_00F0);
    push("logic_x12", 12, 32'h0000_00FF);
    push("logic_x13", 13, 32'h0000_000F);
    run(60);
    drain();

    // x0 immutability and back-to-back dependent chain
    clear_prog();
    imem[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd1);
    imem[1] = enc_i(12'd4, 5'd0, 3'b000, 5'd2);
    imem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0);
    imem[3] = enc_i(12'd1, 5'd0, 3'b000, 5'd14);
    imem[4] = enc_r(7'h00, 5'd14, 5'd14, 3'b000, 5'd14);
    imem[5] = enc_r(7'h00, 5'd14, 5'd14, 3'b000, 5'd14);
    imem[6] = enc_r(7'h00, 5'd14, 5'd14, 3'b000, 5'd14);
    reset_pulse();
    push("chain_x0", 0, 32'd0);
    push("chain_x14", 14, 32'd8);
    run(20);
`ifdef RISCV_FORWARD_EN
    check("chain_pc_no_stall", pcF, 32'd80);
`endif
    run(40);
    drain();

    // reset while the add/sub program is in flight
    load_addsub();
    reset_pulse();
    run(5);
    check("mid_x1_committed", dut.core_inst.u_decode.reg_file[1], 32'd5);
    reset_pulse();
    check("mid_reset_pc", pcF, 32'd0);
    check("mid_reset_regs_nonzero", 32'(nonzero_regs()), 32'd0);
    run(4);
    check("mid_no_stale_commit", 32'(nonzero_regs()), 32'd0);
    push_addsub("rerun");
    run(60);
    drain();

    // unsupported loads between valid instructions
    clear_prog();
    imem[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd15);
    imem[1] = 32'h0000_2803;
    imem[2] = 32'h0000_2003;
    imem[3] = enc_i(12'd1, 5'd15, 3'b000, 5'd17);
    reset_pulse();
    push("unsup_x15", 15, 32'd9);
    push("unsup_x16", 16, 32'd0);
    push("unsup_x17", 17, 32'd10);
    push("unsup_x0", 0, 32'd0);
    run(60);
    drain();
    check("unsup_regs_nonzero", 32'(nonzero_regs()), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/riscv_pipeline.md
# riscv_pipeline

Five-stage in-order RV32I integer pipeline core (IF, ID, EX, MEM, WB) executing register-register (OP) and register-immediate (OP-IMM) ALU instructions. It is the top-level processor block: it drives a fetch address, receives the instruction word combinationally from an external instruction memory, and commits results to an internal 32×32 register file. Verification inspects that register file hierarchically.

## Interface
- No parameters.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-high reset: sampled at the rising edge, reset when 1.
- instrF  input  32  instruction word at address pcF; combinational from the external memory, same cycle.
- pcF  output  32  fetch address, byte-addressed, word-aligned.
- Register file storage is the array reg_file[0:31] inside instance u_decode, inside instance core_inst. Path: core_inst.u_decode.reg_file. It must be readable and writable by hierarchical reference.

## Operation
- Supported OP instructions (opcode 0110011): add, sub, sll, slt, sltu, xor, srl, sra, or, and. Decoding uses funct3 and funct7[5].
- Supported OP-IMM instructions (opcode 0010011): addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - Immediate is sign-extended from bits [31:20].
  - Shift amount is imm[4:0].
- Any other opcode executes as a nop: no register write, no side effects.
- Arithmetic is 32-bit with wrap-around and no overflow traps.
  - Shifts use the low 5 bits of the shift amount. sra/srai replicate bit 31.
  - slt/slti compare signed; sltu/sltiu compare unsigned. Result is 0 or 1.
- x0 always reads 0. Writes to x0 are discarded.
- MEM stage passes the ALU result through unchanged; there is no data memory.
- Hazards:
  - EX→EX and MEM→EX forwarding for rs1 and rs2.
  - WB→ID write-through: a read of the register being written in the same cycle returns the new value.
  - Back-to-back dependent instructions therefore run without stalls.
- No branches, so no flushes. pcF increments by 4 every cycle not in reset.

## Timing
- Reset (rst_n=1 at a rising edge):
  - pcF becomes 0.
  - All pipeline registers become nop (addi x0,x0,0) with write-enable cleared.
  - All 32 reg_file entries become 0.
- Reset asserted mid-operation discards all in-flight instructions; none of them commit.
- First rising edge with rst_n=0: instrF at pcF=0 is latched into IF/ID and pcF becomes 4.
- An instruction presented at edge k commits its reg_file write at edge k+4. The value is visible hierarchically after that edge.
- Throughput is one instruction per cycle.
- pcF wraps from 0xFFFFFFFC to 0x00000000.

## Configuration
- RISCV_FORWARD_EN, when defined: forwarding paths as described above; the pipeline never stalls.
- RISCV_FORWARD_EN, when undefined: no EX/MEM forwarding. Hazard unit behaviour:
  - When the ID-stage instruction reads a non-x0 register that an instruction in EX or MEM will write, hold pcF and IF/ID and inject a nop into EX.
  - Continue until the producer reaches WB; the write-through then resolves the read.
- Architectural results are identical in both builds. Only the cycle count differs.

## Test plan
- Reset then program: addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sub x4,x1,x2, followed by nops. After 300 cycles: x1=5, x2=7, x3=12, x4=0xFFFFFFFE.
- Shift and compare: addi x5,x0,-1; slli x6,x5,31; srai x7,x6,4; srli x8,x6,4; slt x9,x6,x0; sltu x10,x6,x0. Required: x6=0x80000000, x7=0xF8000000, x8=0x08000000, x9=1, x10=0.
- Logic ops: addi x1,x0,0x0F0; addi x2,x0,0x0FF; and x11,x1,x2; or x12,x1,x2; xor x13,x1,x2. Required: x11=0xF0, x12=0xFF, x13=0x0F.
- x0 immutability and forwarding chain: add x0,x1,x2; addi x14,x0,1; add x14,x14,x14 repeated 3 times back-to-back. Required: x0=0, x14=8, with pcF=4·cycles when RISCV_FORWARD_EN is defined.
- Reset mid-run: assert rst_n=1 for one edge while the add/sub program is in flight. Required: pcF=0, all reg_file entries 0, then the program re-executes to the same final values.
- Unsupported opcode (e.g. 0x00002003, lw) inserted between valid instructions. Required: no register change; surrounding results are unaffected.
